// File: rtl/mxv_result_serializer.sv
// Captures wide mxv result words into a small FIFO and streams them out one element per cycle.
// Optional XOR checksum of emitted elements is enabled by defining MXV_RESULT_CHECKSUM_EN.
module mxv_result_serializer #(
    parameter int unsigned element_width = 32,
    parameter int unsigned no_of_units   = 8,
    parameter int unsigned fifo_depth    = 4,
    parameter int unsigned index_width   = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [index_width-1:0]               total_elements,
    input  logic                                 in_valid,
    input  logic [no_of_units*element_width-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [element_width-1:0]             out_data,
    output logic [index_width-1:0]               out_index,
    output logic [$clog2(fifo_depth):0]          fifo_level,
    output logic                                 overflow,
    output logic                                 done
`ifdef MXV_RESULT_CHECKSUM_EN
    ,
    output logic [element_width-1:0]             checksum
`endif
);
    localparam int unsigned AddrW = $clog2(fifo_depth);
    localparam int unsigned SubW  = (no_of_units > 1) ? $clog2(no_of_units) : 1;
    localparam int unsigned WordW = no_of_units * element_width;

    localparam logic [AddrW:0]           DepthCnt = (AddrW + 1)'(fifo_depth);
    localparam logic [AddrW:0]           PtrOne   = (AddrW + 1)'(1);
    localparam logic [SubW-1:0]          SubLast  = SubW'(no_of_units - 1);
    localparam logic [SubW-1:0]          SubOne   = SubW'(1);
    localparam logic [index_width-1:0]   IdxOne   = index_width'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                   state_q, state_d;
    logic [WordW-1:0]         mem_q [fifo_depth];
    logic [AddrW:0]           wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]           rd_ptr_q, rd_ptr_d;
    logic [SubW-1:0]          sub_q, sub_d;
    logic [index_width-1:0]   out_index_q, out_index_d;
    logic [index_width-1:0]   total_q, total_d;
    logic [element_width-1:0] out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overflow_q, overflow_d;

    logic [AddrW:0] level;
    logic           full;
    logic           accept;
    logic           last;
    logic           wrap;
    logic           push;

    // Element 0 sits in the most significant bits of the word.
    function automatic logic [element_width-1:0] pick(input logic [WordW-1:0] word,
                                                      input logic [SubW-1:0]  sel);
        logic [WordW-1:0] shifted;
        shifted = word >> ((no_of_units - 1 - 32'(sel)) * element_width);
        return shifted[element_width-1:0];
    endfunction

    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == DepthCnt);
    assign accept = out_valid_q && out_ready;
    assign last   = accept && (out_index_q == total_q - IdxOne);
    assign wrap   = accept && (sub_q == SubLast);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        sub_d       = sub_q;
        out_index_d = out_index_q;
        total_d     = total_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overflow_d  = overflow_q;
        push        = 1'b0;

        if (start) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            sub_d       = '0;
            out_index_d = '0;
            out_data_d  = '0;
            overflow_d  = 1'b0;
            total_d     = total_elements;
            state_d     = (total_elements == '0) ? StDone : StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (accept) begin
                        out_index_d = out_index_q + IdxOne;
                        sub_d       = wrap ? '0 : sub_q + SubOne;
                    end
                    if (last) begin
                        // Drop the rest of the head word and anything queued behind it.
                        state_d  = StDone;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        sub_d    = '0;
                    end else begin
                        if (wrap) begin
                            rd_ptr_d = rd_ptr_q + PtrOne;
                        end
                        if (in_valid) begin
                            if (!full || wrap) begin
                                push     = 1'b1;
                                wr_ptr_d = wr_ptr_q + PtrOne;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        // Output stage reloads from words already stored, so a push into an
                        // empty FIFO becomes visible one cycle after fifo_level rises.
                        if (wr_ptr_q != rd_ptr_d) begin
                            out_valid_d = 1'b1;
                            out_data_d  = pick(mem_q[rd_ptr_d[AddrW-1:0]], sub_d);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            sub_q       <= '0;
            out_index_q <= '0;
            total_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            sub_q       <= sub_d;
            out_index_q <= out_index_d;
            total_q     <= total_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef MXV_RESULT_CHECKSUM_EN
    logic [element_width-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ out_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign fifo_level = level;
    assign overflow   = overflow_q;
    assign done       = (state_q == StDone);

endmodule

// File: tb/tb_mxv_result_serializer.sv
// Self-checking bench for mxv_result_serializer: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_mxv_result_serializer;
    localparam int EW = 32;
    localparam int NU = 8;
    localparam int FD = 4;
    localparam int IW = 32;
    localparam int WW = EW * NU;
    localparam int LW = $clog2(FD) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] total_elements = '0;
    logic          in_valid = 1'b0;
    logic [WW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [EW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          done;
`ifdef MXV_RESULT_CHECKSUM_EN
    logic [EW-1:0] checksum;
`endif

    mxv_result_serializer #(
        .element_width(EW),
        .no_of_units  (NU),
        .fifo_depth   (FD),
        .index_width  (IW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .total_elements(total_elements),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_index     (out_index),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .done          (done)
`ifdef MXV_RESULT_CHECKSUM_EN
        ,
        .checksum      (checksum)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO as a queue of words, emission as (head word, element offset).
    typedef enum {MIdle, MRun, MDone} mstate_t;
    mstate_t       m_state;
    logic [WW-1:0] m_q[$];
    int unsigned   m_sub;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] m_total;
    bit            m_ovf;
    bit            m_valid;
    logic [EW-1:0] m_data;
    logic [EW-1:0] m_csum;

    logic [EW-1:0] acc_log[$];
    logic [IW-1:0] idx_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] elem_of(input logic [WW-1:0] w, input int unsigned k);
        return w[WW-1-k*EW -: EW];
    endfunction

    function automatic logic [WW-1:0] mk_word(input logic [EW-1:0] base);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < NU; i++) w[WW-1-i*EW -: EW] = base + EW'(i);
        return w;
    endfunction

    task automatic model_reset();
        m_state = MIdle;
        m_q.delete();
        m_sub   = 0;
        m_idx   = '0;
        m_total = '0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_csum  = '0;
    endtask

    // One clock: compare outputs with the model, drive inputs, advance the model.
    task automatic cycle(input bit st, input logic [IW-1:0] te, input bit iv,
                         input logic [WW-1:0] d, input bit rdy);
        bit fin;
        @(negedge clk);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_index", out_index, m_idx);
        end
        chk("fifo_level", fifo_level, m_q.size());
        chk("overflow", overflow, m_ovf);
        chk("done", done, m_state == MDone);
`ifdef MXV_RESULT_CHECKSUM_EN
        chk("checksum", checksum, m_csum);
`endif
        start          = st;
        total_elements = te;
        in_valid       = iv;
        in_data        = d;
        out_ready      = rdy;
        if (out_valid && rdy) begin
            acc_log.push_back(out_data);
            idx_log.push_back(out_index);
        end

        fin = 1'b0;
        if (st) begin
            m_q.delete();
            m_sub   = 0;
            m_idx   = '0;
            m_total = te;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_csum  = '0;
            m_state = (te == 0) ? MDone : MRun;
        end else if (m_state == MRun) begin
            if (m_valid && rdy) begin
                m_csum = m_csum ^ m_data;
                if (m_idx == m_total - 1) begin
                    fin     = 1'b1;
                    m_state = MDone;
                    m_q.delete();
                    m_valid = 1'b0;
                end else begin
                    m_sub++;
                    if (m_sub == NU) begin
                        void'(m_q.pop_front());
                        m_sub = 0;
                    end
                end
                m_idx = m_idx + 1;
            end
            if (!fin) begin
                m_valid = (m_q.size() != 0);
                if (m_valid) m_data = elem_of(m_q[0], m_sub);
                if (iv) begin
                    if (m_q.size() < FD) m_q.push_back(d);
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rdy);
    endtask

    initial begin
        logic [WW-1:0] rw;
        int            n;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;

        // In IDLE in_valid is ignored
        cycle(1'b0, '0, 1'b1, mk_word(32'h99), 1'b1);
        idle_cycles(2, 1'b1);
        chk("idle_level", fifo_level, 0);

        // Basic: one word of elements 1..8
        acc_log.delete();
        idx_log.delete();
        cycle(1'b1, 8, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, mk_word(32'h1), 1'b1);
        idle_cycles(12, 1'b1);
        chk("basic_count", acc_log.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("basic_data", (i < acc_log.size()) ? acc_log[i] : 'x, i + 1);
            chk("basic_index", (i < idx_log.size()) ? idx_log[i] : 'x, i);
        end
        chk("basic_done", done, 1);
        chk("basic_overflow", overflow, 0);
`ifdef MXV_RESULT_CHECKSUM_EN
        chk("basic_checksum", checksum, 32'h8);
`endif

        // Partial last word
        acc_log.delete();
        cycle(1'b1, 10, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, mk_word(32'h10), 1'b1);
        cycle(1'b0, '0, 1'b1, mk_word(32'h20), 1'b1);
        idle_cycles(16, 1'b1);
        chk("partial_count", acc_log.size(), 10);
        for (int i = 0; i < 10; i++)
            chk("partial_data", (i < acc_log.size()) ? acc_log[i] : 'x,
                (i < 8) ? 32'h10 + i : 32'h20 + (i - 8));
        chk("partial_done", done, 1);
        chk("partial_level", fifo_level, 0);

        // Backpressure: data and index held while out_ready is low
        acc_log.delete();
        cycle(1'b1, 8, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, mk_word(32'h1), 1'b0);
        idle_cycles(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 1);
            chk("bp_hold_index", out_index, 0);
        end
        idle_cycles(10, 1'b1);
        chk("bp_count", acc_log.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("bp_data", (i < acc_log.size()) ? acc_log[i] : 'x, i + 1);

        // Overflow: five strobes into a four-deep FIFO
        acc_log.delete();
        cycle(1'b1, 40, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, mk_word(32'h100 * (k + 1)), 1'b0);
        idle_cycles(1, 1'b0);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_flag", overflow, 1);
        idle_cycles(40, 1'b1);
        chk("ovf_count", acc_log.size(), 32);
        for (int i = 0; i < 32; i++)
            chk("ovf_data", (i < acc_log.size()) ? acc_log[i] : 'x,
                32'h100 * (i / 8 + 1) + (i % 8));
        chk("ovf_not_done", done, 0);
        chk("ovf_sticky", overflow, 1);

        // Restart mid-run
        acc_log.delete();
        idx_log.delete();
        cycle(1'b1, 16, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, mk_word(32'h30 + 16 * k), 1'b0);
        n = 0;
        while (acc_log.size() < 3 && n < 30) begin
            cycle(1'b0, '0, 1'b0, '0, 1'b1);
            n++;
        end
        chk("restart_pre_count", acc_log.size(), 3);
        cycle(1'b1, 16, 1'b1, mk_word(32'h77), 1'b0);
        idle_cycles(1, 1'b0);
        chk("restart_level", fifo_level, 0);
        chk("restart_overflow", overflow, 0);
        chk("restart_done", done, 0);
        acc_log.delete();
        idx_log.delete();
        cycle(1'b0, '0, 1'b1, mk_word(32'h50), 1'b1);
        idle_cycles(4, 1'b1);
        chk("restart_first_index", (idx_log.size() > 0) ? idx_log[0] : 'x, 0);
        chk("restart_first_data", (acc_log.size() > 0) ? acc_log[0] : 'x, 32'h50);

        // total_elements == 0
        cycle(1'b1, 0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, mk_word(32'h60), 1'b1);
        chk("zero_done", done, 1);
        chk("zero_level", fifo_level, 0);

        // Asynchronous reset mid-emission
        cycle(1'b1, 8, 1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b1, mk_word(32'h1), 1'b1);
        cycle(1'b0, '0, 1'b1, mk_word(32'h9), 1'b1);
        idle_cycles(3, 1'b1);
        #2;
        start    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset    = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_level", fifo_level, 0);
        chk("arst_overflow", overflow, 0);
`ifdef MXV_RESULT_CHECKSUM_EN
        chk("arst_checksum", checksum, 0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NU; i++) rw[i*EW +: EW] = $urandom;
            cycle(($urandom_range(0, 99) < 2), IW'($urandom_range(0, 30)),
                  ($urandom_range(0, 3) == 0), rw, ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxv_result_serializer.md
Name: mxv_result_serializer

Overview:
- Sits directly downstream of matrix_by_vector_v3_with_control.
- On each read strobe, captures one wide result word: no_of_units elements, element 0 in the MSBs.
- Buffers captured words in a small FIFO, then emits them one element per cycle on a valid/ready stream, tagged with a running element index.
- Emits exactly total_elements elements, then asserts done; later elements are discarded. This replaces the bench's $display of results with a synthesizable consumer.

Parameters:
- element_width, 32, bits per result element
- no_of_units, 8, elements per captured wide word
- fifo_depth, 4, wide words buffered (power of two, >=2)
- index_width, 32, width of element index and total count

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear FIFO, counters and done; enter RUN
- total_elements  in  index_width  elements to emit; sampled on start
- in_valid  in  1  read strobe from multiplier (outsider_read_now)
- in_data  in  no_of_units*element_width  result word (mXv1_result)
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_data  out  element_width  current element
- out_index  out  index_width  global element index, 0-based
- fifo_level  out  $clog2(fifo_depth)+1  words held in FIFO
- overflow  out  1  sticky: in_valid arrived while FIFO full
- done  out  1  all total_elements emitted

Behaviour:
- Reset (reset==0, asynchronous):
  - outputs: out_valid=0, out_data=0, out_index=0, fifo_level=0, overflow=0, done=0
  - state IDLE; FIFO pointers 0; element counter 0; sub-element pointer 0
- States:
  - IDLE: in_valid ignored. start -> RUN.
  - RUN: capture and emit. Last element accepted -> DONE.
  - DONE: done=1, out_valid=0, in_valid ignored. start -> RUN.
- start in any state (RUN included):
  - flush FIFO; clear overflow, done, index and sub-pointer
  - latch total_elements; go to RUN on the next cycle
  - an in_valid in the same cycle as start is dropped
- total_elements==0 at start: go straight to DONE in the next cycle; no elements emitted.
- Capture (RUN only): in_valid && FIFO not full -> push in_data; fifo_level +1 the next cycle.
- Overflow: in_valid with FIFO full -> word dropped, overflow=1. overflow stays set until start or reset.
- Push and pop in the same cycle: allowed; fifo_level unchanged, including when full.
- Emission (RUN):
  - out_valid=1 whenever the FIFO is non-empty.
  - out_data = element sub of the head word. sub=0 is bits [no_of_units*element_width-1 -: element_width].
  - Each accepted transfer: sub+1 and out_index+1.
  - When sub wraps from no_of_units-1 to 0, the head word is popped.
- out_data/out_index are registered: they update in the cycle after an accept or after a push to an empty FIFO.
  - First-element latency: 2 cycles from in_valid to out_valid.
  - Throughput: 1 element/cycle while out_ready=1.
- out_valid=1 && out_ready=0: out_data and out_index held stable (AXI-style, no retraction).
- Last element (index total_elements-1) accepted:
  - the remaining elements of that word are discarded; the word is popped
  - any further FIFO words are flushed
  - state DONE, done=1 the next cycle
- Index arithmetic is unsigned modulo 2^index_width. Compare using equality with total_elements-1.

Optional Feature:
- Macro: MXV_RESULT_CHECKSUM_EN.
- Defined:
  - adds output port checksum, element_width wide, reset 0, cleared on start
  - XOR-accumulates each accepted out_data
  - value is final when done rises and is held in DONE
- Undefined: port absent; no accumulator logic.

Test Plan:
- Basic: reset, start with total=8, one in_valid with words 0x00000001..0x00000008 MSB-first, out_ready=1 -> out_data 1..8 on 8 consecutive cycles; out_index 0..7; done=1 the cycle after index 7; overflow=0.
- Partial last word: total=10, two words 0x10..0x17 then 0x20..0x27 -> emits 0x10..0x17, 0x20, 0x21; elements 0x22..0x27 discarded; done; fifo_level=0.
- Backpressure: total=8, out_ready low for 5 cycles after out_valid -> out_data holds 1, out_index holds 0; then 8 transfers in order.
- Overflow: fifo_depth=4, out_ready=0, 5 in_valid strobes -> fifo_level=4, overflow=1; with out_ready=1, 32 elements of the first 4 words emitted; 5th word absent.
- Restart mid-run: start asserted after 3 elements of total=16 -> FIFO flushed, out_index restarts at 0, done=0, overflow cleared. total=0 start -> done next cycle, out_valid never 1.
- Async reset mid-emission: reset low between clock edges -> out_valid, done and fifo_level go to 0 immediately; with the macro defined, checksum=0. With the macro defined, Basic test -> checksum=0x00000008.
